store_buffer: RTL and testbench

- Sits directly downstream of the single-cycle datapath, between its memory outputs (ALUResult, WriteData) and data memory.
- Accepts stores in one cycle and queues them in a small FIFO. Drains the queue to a slower data-memory write port over a valid/ready handshake.
- Returns load data to the datapath's ReadData input, forwarding from queued stores when the address matches.
- Raises Stall when a store arrives and the queue is full; Stall drives the PC/regfile write-enable hold.

---
 rtl/store_buffer.sv | 115 +++++++++++
 tb/tb_store_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the single-cycle datapath and data memory.
// Stores are accepted in one cycle into a small FIFO and drained in program
// order over a valid/ready write port. Loads are served combinationally,
// forwarding from the youngest matching queued store.
module store_buffer #(
  parameter int unsigned width = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWrite,
  input  logic [width-1:0] ALUResult,
  input  logic [width-1:0] WriteData,
  output logic [width-1:0] ReadData,
  output logic             Stall,
  output logic             Empty,
  output logic [width-1:0] mem_raddr,
  input  logic [width-1:0] mem_rdata,
  output logic             bus_wvalid,
  output logic [width-1:0] bus_waddr,
  output logic [width-1:0] bus_wdata,
  input  logic             bus_wready
);

  localparam logic [PTRW:0] CntFull = (PTRW + 1)'(DEPTH);

  // Entry storage and queue bookkeeping
  logic [width-1:0] addr_q [DEPTH];
  logic [width-1:0] addr_d [DEPTH];
  logic [width-1:0] data_q [DEPTH];
  logic [width-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]    count_q, count_d;

  logic full, enq, deq;

  // Handshake qualifiers; a full queue never bypasses, even if the head drains now
  always_comb begin
    full       = (count_q == CntFull);
    Stall      = MemWrite && full;
    enq        = MemWrite && !full;
    bus_wvalid = (count_q != '0);
    deq        = bus_wvalid && bus_wready;
    Empty      = (count_q == '0);
    bus_waddr  = addr_q[rd_ptr_q];
    bus_wdata  = data_q[rd_ptr_q];
  end

  // Next-state for entries, pointers and occupancy
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    // Enqueue and dequeue never target the same slot: that needs full or empty
    if (enq) begin
      addr_d[wr_ptr_q]  = {ALUResult[width-1:2], 2'b00};
      data_d[wr_ptr_q]  = WriteData;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared asynchronously so queued stores are discarded at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Load path: scan oldest to youngest so the youngest match wins
  always_comb begin
    logic [PTRW-1:0] idx;
    idx       = rd_ptr_q;
    mem_raddr = ALUResult;
    ReadData  = mem_rdata;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + i[PTRW-1:0];
      if (valid_q[idx] && (addr_q[idx][width-1:2] == ALUResult[width-1:2])) begin
        ReadData = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst_n;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Empty;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        bus_wvalid;
  logic [31:0] bus_waddr;
  logic [31:0] bus_wdata;
  logic        bus_wready;

  logic [31:0] salt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];

  store_buffer #(
    .width(32),
    .DEPTH(Depth),
    .PTRW (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Empty     (Empty),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .bus_wvalid(bus_wvalid),
    .bus_waddr (bus_waddr),
    .bus_wdata (bus_wdata),
    .bus_wready(bus_wready)
  );

  // Backing memory stand-in: data is a fixed function of the read address
  assign mem_rdata = mem_raddr ^ salt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the inputs currently applied
  task automatic check_outputs();
    logic [31:0] exp_rd;
    logic [31:0] word;
    word   = ALUResult & 32'hFFFF_FFFC;
    exp_rd = ALUResult ^ salt;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].a == word) exp_rd = q[i].d;
    end
    chk("stall", {31'b0, Stall}, {31'b0, MemWrite && (q.size() == Depth)});
    chk("empty", {31'b0, Empty}, {31'b0, q.size() == 0});
    chk("wvalid", {31'b0, bus_wvalid}, {31'b0, q.size() != 0});
    chk("raddr", mem_raddr, ALUResult);
    chk("rdata", ReadData, exp_rd);
    if (q.size() != 0) begin
      chk("waddr", bus_waddr, q[0].a);
      chk("wdata", bus_wdata, q[0].d);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, check, then clock the model
  task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d,
                     input logic wr);
    ent_t e;
    logic do_enq, do_deq;
    MemWrite   = mw;
    ALUResult  = a;
    WriteData  = d;
    bus_wready = wr;
    #1;
    check_outputs();
    do_enq = mw && (q.size() < Depth);
    do_deq = wr && (q.size() != 0);
    @(posedge clk);
    if (do_deq) void'(q.pop_front());
    if (do_enq) begin
      e.a = a & 32'hFFFF_FFFC;
      e.d = d;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    MemWrite   = 1'b0;
    ALUResult  = 32'h0;
    WriteData  = 32'h0;
    bus_wready = 1'b0;
    salt       = 32'hDEAD_BEEF;

    // Reset then idle
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_wvalid", {31'b0, bus_wvalid}, 32'h0);
    chk("rst_empty", {31'b0, Empty}, 32'h1);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_waddr", bus_waddr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("idle_rdata", ReadData, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);

    // Single store, hold stable while not ready, then drain
    cyc(1'b1, 32'h10, 32'h1111_1111, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("single_waddr", bus_waddr, 32'h10);
    chk("single_wdata", bus_wdata, 32'h1111_1111);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("single_empty", {31'b0, Empty}, 32'h1);

    // Forwarding: youngest matching word wins, low address bits ignored
    salt = 32'h1234_5678;
    cyc(1'b1, 32'h20, 32'hA, 1'b0);
    cyc(1'b1, 32'h24, 32'hB, 1'b0);
    cyc(1'b1, 32'h21, 32'hC, 1'b0);
    ALUResult = 32'h20;
    #1;
    chk("fwd_youngest", ReadData, 32'hC);
    cyc(1'b0, 32'h20, 32'h0, 1'b0);
    cyc(1'b0, 32'h26, 32'h0, 1'b0);
    cyc(1'b0, 32'h30, 32'h0, 1'b0);
    // Head being handed off still forwards
    cyc(1'b0, 32'h20, 32'h0, 1'b1);
    cyc(1'b0, 32'h24, 32'h0, 1'b1);
    cyc(1'b0, 32'h20, 32'h0, 1'b1);

    // Full and stall, retried store enqueues after the head drains
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h40 + 4 * i, 32'h100 + i, 1'b0);
    cyc(1'b1, 32'h50, 32'h104, 1'b1);
    cyc(1'b1, 32'h50, 32'h104, 1'b0);
    chk("full_count", q.size(), 32'd4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h50, 32'h0, 1'b1);

    // Simultaneous enqueue and dequeue at count 2
    cyc(1'b1, 32'h60, 32'h600, 1'b0);
    cyc(1'b1, 32'h64, 32'h601, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h68 + 4 * i, 32'h602 + i, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1);

    // Asynchronous reset while entries are queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h80 + 4 * i, 32'h800 + i, 1'b0);
    bus_wready = 1'b0;
    MemWrite   = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("mid_rst_wvalid", {31'b0, bus_wvalid}, 32'h0);
    chk("mid_rst_empty", {31'b0, Empty}, 32'h1);
    q.delete();
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 32'h80, 32'h0, 1'b1);
    cyc(1'b0, 32'h84, 32'h0, 1'b1);

    // Random traffic over a small address window to exercise forwarding
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 99) < 55), 32'h100 + 32'($urandom_range(0, 31)),
          $urandom, 1'($urandom_range(0, 99) < 40));
    end
    for (int n = 0; n < 6; n++) cyc(1'b0, 32'h0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
